// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// datapath widths, the sequential PC increment and the flush word.
package if_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  PC_INC      = 32'd4;
    localparam logic [INSTR_W-1:0] FLUSH_INSTR = 32'h0000_0000;

    // FETCH: request outstanding; HOLD: word parked while stalled;
    // DROP: in-flight word belongs to the wrong path and will be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Sequential successor; wraps naturally modulo 2^32.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] addr);
        return addr + PC_INC;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry buffer that parks a fetched word and its successor address
// while the downstream stage is stalled.
module if_skid_buf
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W-1:0]  load_addr,
    output logic               full,
    output logic [INSTR_W-1:0] data,
    output logic [ADDR_W-1:0]  addr
);

    // Occupancy flag: load wins over clear when both are requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    // Payload capture.
    // NOTE: the payload has no reset; it is only ever read while full=1,
    // so resetting it would add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (load) begin
            data <= load_data;
            addr <= load_addr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential requests to instruction
// memory, presents returned words downstream, parks one word during a
// stall and discards in-flight words after a branch redirect.
module if_stage
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freez,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_reg_next;
    logic [ADDR_W-1:0]   redirect, redirect_next;
    logic [ADDR_W-1:0]   pc_next;
    logic [INSTR_W-1:0]  instr_next;
    logic                valid_next;
    logic                buf_load, buf_clear, buf_full;
    logic [INSTR_W-1:0]  buf_data;
    logic [ADDR_W-1:0]   buf_addr;
    logic                ack;
    logic [ADDR_W-1:0]   seq_pc;

    // Request is silenced during reset so nothing is issued from a stale
    // address; an ack only counts while our request is actually asserted,
    // which also discards a late ack left over from before a reset.
    assign imem_req  = rst && (state != HOLD);
    assign imem_addr = pc_reg;
    assign ack       = imem_ack && imem_req;
    assign seq_pc    = next_pc(pc_reg);

    if_skid_buf u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_data (imem_rdata),
        .load_addr (seq_pc),
        .full      (buf_full),
        .data      (buf_data),
        .addr      (buf_addr)
    );

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers sample pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control for every register of the stage.
    // NOTE: all outputs of this block receive a default first, so no path
    // through the case statement can leave a value unassigned (no latch).
    always_comb begin
        state_next    = state;
        pc_reg_next   = pc_reg;
        redirect_next = redirect;
        pc_next       = pc;
        instr_next    = instruction;
        valid_next    = valid;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        // A redirect always flushes the presented slot, stall or not.
        if (branch_taken) begin
            valid_next = 1'b0;
            instr_next = FLUSH_INSTR;
        end

        case (state)
            FETCH: begin
                if (branch_taken) begin
                    if (ack) begin
                        pc_reg_next = branch_addr;
                    end else begin
                        // Address must stay put until the wrong-path ack.
                        redirect_next = branch_addr;
                        state_next    = DROP;
                    end
                end else if (ack) begin
                    pc_reg_next = seq_pc;
                    if (!freez) begin
                        pc_next    = seq_pc;
                        instr_next = imem_rdata;
                        valid_next = 1'b1;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = HOLD;
                    end
                end else if (!freez) begin
                    valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    buf_clear   = 1'b1;
                    pc_reg_next = branch_addr;
                    state_next  = FETCH;
                end else if (!freez) begin
                    pc_next    = buf_addr;
                    instr_next = buf_data;
                    valid_next = buf_full;
                    buf_clear  = 1'b1;
                    state_next = FETCH;
                end
            end

            DROP: begin
                if (ack) begin
                    // Newest target wins if a branch coincides with the ack.
                    pc_reg_next = branch_taken ? branch_addr : redirect;
                    state_next  = FETCH;
                end else if (branch_taken) begin
                    redirect_next = branch_addr;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Fetch address, redirect target and presented instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg      <= RESET_PC;
            redirect    <= RESET_PC;
            pc          <= '0;
            instruction <= FLUSH_INSTR;
            valid       <= 1'b0;
        end else begin
            pc_reg      <= pc_reg_next;
            redirect    <= redirect_next;
            pc          <= pc_next;
            instruction <= instr_next;
            valid       <= valid_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Expected presentations are queued when the
// accepting ack is driven and popped when the stage should present them.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freez;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freez        (freez),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instruction  (instruction),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic frz,
                         input logic br, input logic [31:0] baddr);
        imem_ack     = ack;
        imem_rdata   = rdata;
        freez        = frz;
        branch_taken = br;
        branch_addr  = baddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, 32'(imem_req), 32'(req));
        if (req) check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic expect_present(input string tag);
        exp_t e;
        check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(valid), 32'd1);
            check({tag, "_pc"}, pc, e.pc);
            check({tag, "_instr"}, instruction, e.instr);
        end
    endtask

    task automatic expect_flushed(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_instr"}, instruction, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset state.
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);

        // Release: zero-wait memory streams A, B, C.
        rst = 1'b1;
        #1;
        expect_req("rel", 1'b1, 32'h0);
        drive(1'b1, 32'hA000_000A, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h4, instr: 32'hA000_000A});
        tick();
        expect_present("stream_a");
        expect_req("stream_a", 1'b1, 32'h4);
        drive(1'b1, 32'hB000_000B, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h8, instr: 32'hB000_000B});
        tick();
        expect_present("stream_b");
        expect_req("stream_b", 1'b1, 32'h8);
        drive(1'b1, 32'hC000_000C, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'hC, instr: 32'hC000_000C});
        tick();
        expect_present("stream_c");
        expect_req("stream_c", 1'b1, 32'hC);

        // Stall on an ack: word D parked, request drops, outputs hold C.
        drive(1'b1, 32'hD000_000D, 1'b1, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h10, instr: 32'hD000_000D});
        tick();
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_pc", pc, 32'hC);
        check("hold_instr", instruction, 32'hC000_000C);
        check("hold_valid", 32'(valid), 32'd1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        tick();
        check("hold2_req", 32'(imem_req), 32'd0);
        check("hold2_instr", instruction, 32'hC000_000C);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        expect_present("unstall_d");
        expect_req("unstall_d", 1'b1, 32'h10);

        // Branch with ack three cycles late: address held, word dropped.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        tick();
        expect_flushed("br_late0");
        expect_req("br_late0", 1'b1, 32'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        expect_flushed("br_late1");
        expect_req("br_late1", 1'b1, 32'h10);
        tick();
        expect_flushed("br_late2");
        expect_req("br_late2", 1'b1, 32'h10);
        drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
        tick();
        expect_flushed("br_drop");
        expect_req("br_drop", 1'b1, 32'h100);

        // Second redirect in DROP overwrites the first target.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
        tick();
        expect_req("drop_ovr", 1'b1, 32'h100);
        drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
        tick();
        expect_flushed("drop_ovr");
        expect_req("drop_ovr_tgt", 1'b1, 32'h300);

        // Bubble when no ack and no stall; hold when no ack and stalled.
        drive(1'b1, 32'hE000_000E, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h304, instr: 32'hE000_000E});
        tick();
        expect_present("word_e");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bubble_valid", 32'(valid), 32'd0);
        drive(1'b1, 32'hF000_000F, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h308, instr: 32'hF000_000F});
        tick();
        expect_present("word_f");
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        check("stall_noack_valid", 32'(valid), 32'd1);
        check("stall_noack_pc", pc, 32'h308);

        // Branch while HOLD: parked word G discarded.
        drive(1'b1, 32'h6000_0006, 1'b1, 1'b0, 32'h0);
        tick();
        check("hold_g_req", 32'(imem_req), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
        tick();
        expect_flushed("hold_br");
        expect_req("hold_br", 1'b1, 32'h400);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("hold_br_after_valid", 32'(valid), 32'd0);

        // Branch coinciding with ack in FETCH, then wrap at the top.
        drive(1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        expect_flushed("br_ack");
        expect_req("br_ack", 1'b1, 32'hFFFF_FFFC);
        drive(1'b1, 32'h7000_0007, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h0, instr: 32'h7000_0007});
        tick();
        expect_present("wrap");
        expect_req("wrap", 1'b1, 32'h0);

        // Reset mid-request; ack arriving during reset is ignored.
        drive(1'b1, 32'h1000_0001, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h4, instr: 32'h1000_0001});
        tick();
        expect_present("pre_rst");
        expect_req("pre_rst", 1'b1, 32'h4);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_instr", instruction, 32'h0);
        drive(1'b1, 32'hBAD0_0004, 1'b0, 1'b0, 32'h0);
        tick();
        check("late_ack_valid", 32'(valid), 32'd0);
        check("late_ack_req", 32'(imem_req), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        expect_req("rel2", 1'b1, 32'h0);
        drive(1'b1, 32'h2000_0002, 1'b0, 1'b0, 32'h0);
        sb.push_back('{pc: 32'h4, instr: 32'h2000_0002});
        tick();
        expect_present("post_rst");
        expect_req("post_rst", 1'b1, 32'h4);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-004 SHALL have port freez  input  1  downstream stall; hold the presented instruction.
REQ-005 SHALL have port branch_taken  input  1  redirect request, flushes fetch path.
REQ-006 SHALL have port branch_addr  input  32  redirect target.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  request address.
REQ-009 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port pc  output  32  fetch address + 4 of the presented instruction.
REQ-012 SHALL have port instruction  output  32  presented instruction.
REQ-013 SHALL have port valid  output  1  pc/instruction hold a real instruction.

Function
REQ-014 SHALL keep internal pc_reg; imem_addr SHALL equal pc_reg whenever imem_req=1.
REQ-015 SHALL implement FSM states FETCH, HOLD, DROP.
REQ-016 SHALL drive imem_req: FETCH=1, DROP=1, HOLD=0.
REQ-017 SHALL keep imem_req and imem_addr stable from assertion until the imem_ack cycle.
REQ-018 FETCH + ack, no branch, freez=0: pc<=pc_reg+4, instruction<=imem_rdata, valid<=1, pc_reg<=pc_reg+4, stay FETCH.
REQ-019 FETCH + ack, no branch, freez=1: capture word and address into a one-entry buffer, pc_reg<=pc_reg+4, go HOLD; outputs unchanged.
REQ-020 HOLD + freez=0, no branch: present buffer contents with valid<=1, clear buffer, go FETCH.
REQ-021 FETCH, no ack, no branch, freez=0: valid<=0 (bubble); freez=1: outputs hold.
REQ-022 branch_taken in any state SHALL set valid<=0 and instruction<=0 next edge, regardless of freez.
REQ-023 branch_taken with ack in FETCH or DROP: discard word, pc_reg<=branch_addr, go FETCH.
REQ-024 branch_taken in FETCH without ack: pc_reg unchanged until ack; go DROP, target held in a redirect register.
REQ-025 DROP + ack: discard word, pc_reg<=redirect target, go FETCH; further branch_taken in DROP SHALL overwrite the target.
REQ-026 branch_taken in HOLD: clear buffer, pc_reg<=branch_addr, go FETCH.
REQ-027 pc_reg+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000; pc output likewise).
REQ-028 Zero-wait memory (ack in request cycle) SHALL sustain one instruction per cycle, latency 1 edge from ack to valid.

Reset
REQ-029 rst=0 SHALL asynchronously set pc_reg=RESET_PC, state=FETCH, buffer empty, pc=0, instruction=0, valid=0.
REQ-030 imem_req SHALL be 0 while rst=0 and assert in the first cycle after release.
REQ-031 Reset during an outstanding request SHALL abandon it; a late imem_ack SHALL be ignored until imem_req re-asserts.

Structure
REQ-032 Shared package if_pkg SHALL hold the state enum, PC_INC=4, INSTR_W=32 and the flush value 32'h0.
REQ-033 The one-entry buffer SHALL be sub-module if_skid_buf (load, clear, full flag, data+addr).

Verification
REQ-034 Reset release, RESET_PC=0, ack every cycle, words A,B,C -> imem_addr 0,4,8; valid from cycle 2 with pc 4,8,12.
REQ-035 freez=1 on cycle B acks -> B buffered, imem_req=0, outputs hold A; freez=0 -> B presented, then fetch at 8.
REQ-036 branch_taken, branch_addr=32'h100, ack late by 3 cycles -> imem_addr held 4 until ack, word dropped, next imem_addr=32'h100, valid=0 throughout.
REQ-037 branch_taken during HOLD -> buffer cleared, valid=0, next imem_addr=branch_addr.
REQ-038 pc_reg=32'hFFFF_FFFC, ack -> pc output 0, next imem_addr 0.
REQ-039 rst asserted mid-request, ack in the following cycle -> ignored; first request after release at RESET_PC.
